// File: rtl/fetch_unit.sv
// PC + instruction register stage: addresses combinational imem, presents IR to decode via valid/ready.
// Latency 1 cycle pc->ir; back-pressure holds pc/ir; redirect flushes with one bubble; HALT_WORD stops fetch.
module fetch_unit #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter logic [15:0] HALT_WORD = 16'hFFFF,
    parameter logic [15:0] NOP_WORD  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  pc,
    input  logic [15:0] inst_in,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    input  logic        ir_ready,
    output logic [15:0] ir,
    output logic [7:0]  ir_pc,
    output logic        ir_valid,
    output logic        halted
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        halted_q, halted_d;
    logic        advance;

    // IR may be overwritten when empty or when decode takes it this cycle
    assign advance = !ir_valid_q || ir_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;

        if (state_q == ST_RUN) begin
            if (redirect) begin
                pc_d       = redirect_pc;
                ir_valid_d = 1'b0;
                ir_d       = NOP_WORD;
            end else if (advance) begin
                ir_d       = inst_in;
                ir_pc_d    = pc_q;
                ir_valid_d = 1'b1;
                if (inst_in == HALT_WORD) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
            end
        end else begin
            // Only drain the HALT word already in IR; nothing new is fetched
            if (ir_valid_q && ir_ready) begin
                ir_valid_d = 1'b0;
                ir_d       = NOP_WORD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            ir_q       <= NOP_WORD;
            ir_pc_q    <= 8'h00;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-cycle vectors plus hand sequences for reset and wrap-around.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc;
    logic [15:0] inst_in;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        ir_ready;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        halted;

    logic        rst2;
    logic [7:0]  pc2;
    logic [15:0] inst_in2;
    logic [15:0] ir2;
    logic [7:0]  ir_pc2;
    logic        ir_valid2;
    logic        halted2;
    logic        redirect2 = 1'b0;
    logic [7:0]  redirect_pc2 = 8'h00;
    logic        ir_ready2 = 1'b1;

    logic [15:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign inst_in  = mem[pc];
    assign inst_in2 = mem[pc2];

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .pc(pc), .inst_in(inst_in),
        .redirect(redirect), .redirect_pc(redirect_pc), .ir_ready(ir_ready),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted)
    );

    fetch_unit #(.RESET_PC(8'hFE)) u_dut_fe (
        .clk(clk), .rst(rst2), .pc(pc2), .inst_in(inst_in2),
        .redirect(redirect2), .redirect_pc(redirect_pc2), .ir_ready(ir_ready2),
        .ir(ir2), .ir_pc(ir_pc2), .ir_valid(ir_valid2), .halted(halted2)
    );

    typedef struct packed {
        logic        rdy;
        logic        redir;
        logic [7:0]  rpc;
        logic [15:0] e_ir;
        logic [7:0]  e_irpc;
        logic [7:0]  e_pc;
        logic        e_vld;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_ir, input logic [7:0] e_irpc,
                           input logic [7:0] e_pc, input logic e_vld, input logic e_halt);
        chk({tag, ".ir"},       ir,                 e_ir);
        chk({tag, ".ir_pc"},    {8'h00, ir_pc},     {8'h00, e_irpc});
        chk({tag, ".pc"},       {8'h00, pc},        {8'h00, e_pc});
        chk({tag, ".ir_valid"}, {15'h0, ir_valid},  {15'h0, e_vld});
        chk({tag, ".halted"},   {15'h0, halted},    {15'h0, e_halt});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  fe_irpc [4];
        logic [15:0] fe_ir   [4];
        logic [7:0]  fe_pc   [4];

        // mem[i] = {i, ~i}; never HALT_WORD except where planted
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = i[7:0];
            mem[i] = {a, ~a};
        end
        mem[5] = 16'hFFFF;

        //                 rdy  redir rpc    ir        irpc   pc     vld  halt
        // stream A,B then stall 3 cycles on B, release to C,D
        vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h00FF, 8'h00, 8'h01, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h01FE, 8'h01, 8'h02, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h01FE, 8'h01, 8'h02, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h01FE, 8'h01, 8'h02, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h01FE, 8'h01, 8'h02, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h02FD, 8'h02, 8'h03, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h03FC, 8'h03, 8'h04, 1'b1, 1'b0});
        // redirect to 0x40 under back-pressure: bubble, then mem[0x40]
        vecs.push_back('{1'b0, 1'b1, 8'h40, 16'h0000, 8'h03, 8'h40, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h40BF, 8'h40, 8'h41, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h41BE, 8'h41, 8'h42, 1'b1, 1'b0});
        // park pc on the HALT word; redirect in the same cycle must win
        vecs.push_back('{1'b1, 1'b1, 8'h05, 16'h0000, 8'h41, 8'h05, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h10, 16'h0000, 8'h41, 8'h10, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h05, 16'h0000, 8'h41, 8'h05, 1'b0, 1'b0});
        // fetch HALT, hold under stall, ignore redirect, drain, stay empty
        vecs.push_back('{1'b1, 1'b0, 8'h00, 16'hFFFF, 8'h05, 8'h05, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'hFFFF, 8'h05, 8'h05, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 8'h20, 16'hFFFF, 8'h05, 8'h05, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0000, 8'h05, 8'h05, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'h30, 16'h0000, 8'h05, 8'h05, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0000, 8'h05, 8'h05, 1'b0, 1'b1});

        rst         = 1'b1;
        rst2        = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        ir_ready    = 1'b1;

        tick();
        tick();
        chk_all("reset", 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        for (int v = 0; v < vecs.size(); v++) begin
            ir_ready    = vecs[v].rdy;
            redirect    = vecs[v].redir;
            redirect_pc = vecs[v].rpc;
            tick();
            chk_all($sformatf("vec%0d", v), vecs[v].e_ir, vecs[v].e_irpc,
                    vecs[v].e_pc, vecs[v].e_vld, vecs[v].e_halt);
        end

        // reset out of HALT restarts at RESET_PC
        redirect = 1'b0;
        ir_ready = 1'b0;
        rst      = 1'b1;
        tick();
        chk_all("halt_rst", 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("restart", 16'h00FF, 8'h00, 8'h01, 1'b1, 1'b0);
        tick();
        chk_all("restall", 16'h00FF, 8'h00, 8'h01, 1'b1, 1'b0);
        // reset while stalled with a valid IR
        rst = 1'b1;
        tick();
        chk_all("stall_rst", 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0);
        rst      = 1'b0;
        ir_ready = 1'b1;

        // second instance: RESET_PC=FE wraps through FF to 00
        chk("fe.reset_pc", {8'h00, pc2}, 16'h00FE);
        chk("fe.reset_vld", {15'h0, ir_valid2}, 16'h0000);
        fe_irpc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        fe_ir   = '{16'hFE01, 16'hFF00, 16'h00FF, 16'h01FE};
        fe_pc   = '{8'hFF, 8'h00, 8'h01, 8'h02};
        rst2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("fe%0d.ir_pc", k), {8'h00, ir_pc2}, {8'h00, fe_irpc[k]});
            chk($sformatf("fe%0d.ir", k),    ir2,             fe_ir[k]);
            chk($sformatf("fe%0d.pc", k),    {8'h00, pc2},    {8'h00, fe_pc[k]});
            chk($sformatf("fe%0d.vld", k),   {15'h0, ir_valid2}, 16'h0001);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
